// File: rtl/painterengine_gpu_dma_write_scheduler.sv
// Round-robin arbiter sharing one GPU DMA writer among 4 requesters; one job in flight at a time.
// Grant->router 1 cycle, router->writer start 1 cycle; requests simply wait while a job is in flight.
module painterengine_gpu_dma_write_scheduler #(
    parameter int unsigned PARAM_RELEASE_CYCLES = 2,
    parameter int unsigned PARAM_JOB_TIMEOUT    = 0
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_enable,
    input  logic [3:0]  i_wire_request,
    output logic [3:0]  o_wire_done,
    output logic [3:0]  o_wire_error,
    output logic        o_wire_busy,
    output logic [15:0] o_wire_job_count,
    output logic        o_wire_writer_resetn,
    output logic [3:0]  o_wire_writer_router,
    input  logic        i_wire_writer_done,
    input  logic        i_wire_writer_error
);

    typedef enum logic [1:0] {IDLE, SELECT, RUN, RELEASE} state_t;

    localparam logic [31:0] TIMEOUT      = 32'(PARAM_JOB_TIMEOUT);
    localparam logic [31:0] RELEASE_LAST = 32'(PARAM_RELEASE_CYCLES - 1);

    state_t      state;
    logic [1:0]  last_grant;
    logic [3:0]  mask;
    logic [31:0] run_cnt;
    logic [31:0] rel_cnt;

    logic [3:0]  eligible;
    logic [1:0]  next_ch;
    logic [1:0]  idx;
    logic        found;
    logic        timeout_hit;

    // Search starts one past the last grant; k=4 wraps back onto last_grant itself.
    always_comb begin
        eligible = i_wire_request & ~mask;
        next_ch  = last_grant;
        idx      = '0;
        found    = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                next_ch = idx;
            end
        end
    end

    // Fires on the cycle the counter would reach the limit, i.e. PARAM_JOB_TIMEOUT cycles into RUN.
    assign timeout_hit = (TIMEOUT != 32'd0) && ((run_cnt + 32'd1) == TIMEOUT);
    assign o_wire_busy = (state != IDLE);

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state                <= IDLE;
            last_grant           <= 2'd3;
            mask                 <= '0;
            run_cnt              <= '0;
            rel_cnt              <= '0;
            o_wire_done          <= '0;
            o_wire_error         <= '0;
            o_wire_job_count     <= '0;
            o_wire_writer_resetn <= 1'b0;
            o_wire_writer_router <= '0;
        end else begin
            o_wire_done  <= '0;
            o_wire_error <= '0;
            mask         <= mask & i_wire_request;
            case (state)
                IDLE: begin
                    o_wire_writer_resetn <= 1'b0;
                    if (i_wire_enable && found) begin
                        o_wire_writer_router <= 4'b0001 << next_ch;
                        last_grant           <= next_ch;
                        state                <= SELECT;
                    end
                end
                SELECT: begin
                    o_wire_writer_resetn <= 1'b1;
                    run_cnt              <= '0;
                    state                <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt + 32'd1;
                    if (i_wire_writer_error || timeout_hit || i_wire_writer_done) begin
                        if (i_wire_writer_error || timeout_hit) begin
                            o_wire_error <= o_wire_writer_router;
                        end else begin
                            o_wire_done <= o_wire_writer_router;
                        end
                        // A requester dropping its line this very cycle has already retired the job.
                        mask                 <= (mask | o_wire_writer_router) & i_wire_request;
                        o_wire_job_count     <= o_wire_job_count + 16'd1;
                        o_wire_writer_resetn <= 1'b0;
                        run_cnt              <= '0;
                        rel_cnt              <= '0;
                        state                <= RELEASE;
                    end
                end
                RELEASE: begin
                    o_wire_writer_resetn <= 1'b0;
                    if (rel_cnt == RELEASE_LAST) begin
                        o_wire_writer_router <= '0;
                        rel_cnt              <= '0;
                        state                <= IDLE;
                    end else begin
                        rel_cnt <= rel_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_dma_write_scheduler.sv
// Directed bench for the DMA write scheduler: default instance plus a 100-cycle watchdog instance.
module tb_painterengine_gpu_dma_write_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  req;
    logic        wdone, werr;
    logic [3:0]  done, err;
    logic        busy;
    logic [15:0] jcnt;
    logic        wrst_n;
    logic [3:0]  router;

    logic [3:0]  req_t;
    logic        wdone_t, werr_t;
    logic [3:0]  done_t, err_t;
    logic        busy_t;
    logic [15:0] jcnt_t;
    logic        wrst_n_t;
    logic [3:0]  router_t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    painterengine_gpu_dma_write_scheduler dut (
        .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_enable(en),
        .i_wire_request(req), .o_wire_done(done), .o_wire_error(err),
        .o_wire_busy(busy), .o_wire_job_count(jcnt),
        .o_wire_writer_resetn(wrst_n), .o_wire_writer_router(router),
        .i_wire_writer_done(wdone), .i_wire_writer_error(werr)
    );

    painterengine_gpu_dma_write_scheduler #(.PARAM_RELEASE_CYCLES(2), .PARAM_JOB_TIMEOUT(100)) dut_to (
        .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_enable(en),
        .i_wire_request(req_t), .o_wire_done(done_t), .o_wire_error(err_t),
        .o_wire_busy(busy_t), .o_wire_job_count(jcnt_t),
        .o_wire_writer_resetn(wrst_n_t), .o_wire_writer_router(router_t),
        .i_wire_writer_done(wdone_t), .i_wire_writer_error(werr_t)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        resetn = 1'b0;
        req    = '0;
        wdone  = 1'b0;
        werr   = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    // Wait for a grant, let the writer run a few cycles, then finish it with done and/or error.
    task automatic do_job(input string tag, input logic [3:0] exp, input logic use_done, input logic use_err);
        int n;
        n = 0;
        while (router == 4'd0 && n < 10) begin step(); n++; end
        check({tag, "_grant"}, 16'(router), 16'(exp));
        n = 0;
        while (!wrst_n && n < 10) begin step(); n++; end
        check({tag, "_start"}, 16'(wrst_n), 16'd1);
        repeat (3) step();
        wdone = use_done;
        werr  = use_err;
        step();
        wdone = 1'b0;
        werr  = 1'b0;
        check({tag, "_done"},  16'(done), use_err ? 16'd0 : 16'(exp));
        check({tag, "_error"}, 16'(err),  use_err ? 16'(exp) : 16'd0);
        n = 0;
        while (busy && n < 10) begin step(); n++; end
        check({tag, "_idle"}, 16'(busy), 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        resetn  = 1'b0;
        en      = 1'b1;
        req     = '0;
        wdone   = 1'b0;
        werr    = 1'b0;
        req_t   = '0;
        wdone_t = 1'b0;
        werr_t  = 1'b0;

        // Reset values
        do_reset();
        check("rst_wresetn", 16'(wrst_n), 16'd0);
        check("rst_router",  16'(router), 16'd0);
        check("rst_busy",    16'(busy),   16'd0);
        check("rst_pulses",  16'({done, err}), 16'd0);
        check("rst_count",   jcnt, 16'd0);

        // 1) single job on ch0, exact latency
        req = 4'b0001;
        step();
        check("t1_router_n1",  16'(router), 16'h1);
        check("t1_wresetn_n1", 16'(wrst_n), 16'd0);
        step();
        check("t1_wresetn_n2", 16'(wrst_n), 16'd1);
        repeat (19) step();
        check("t1_no_early_done", 16'(done), 16'd0);
        wdone = 1'b1;
        step();
        wdone = 1'b0;
        req   = 4'b0000;
        check("t1_done",         16'(done),   16'h1);
        check("t1_count",        jcnt,        16'd1);
        check("t1_wresetn_low",  16'(wrst_n), 16'd0);
        check("t1_router_held",  16'(router), 16'h1);
        step();
        check("t1_pulse_width",  16'(done),   16'd0);
        check("t1_busy_release", 16'(busy),   16'd1);
        step();
        check("t1_busy_end",     16'(busy),   16'd0);
        check("t1_router_end",   16'(router), 16'd0);

        // 2) round robin with all requests held; masked channels wait for a low cycle
        do_reset();
        req = 4'b1111;
        do_job("t2_j0", 4'b0001, 1'b1, 1'b0);
        do_job("t2_j1", 4'b0010, 1'b1, 1'b0);
        do_job("t2_j2", 4'b0100, 1'b1, 1'b0);
        do_job("t2_j3", 4'b1000, 1'b1, 1'b0);
        repeat (5) step();
        check("t2_masked_router", 16'(router), 16'd0);
        check("t2_masked_busy",   16'(busy),   16'd0);
        req = 4'b0000;
        step();
        req = 4'b1111;
        do_job("t2_j4", 4'b0001, 1'b1, 1'b0);
        check("t2_count", jcnt, 16'd5);

        // 3) done and error together: error wins, still counted
        req = 4'b0000;
        step();
        req = 4'b0100;
        do_job("t3", 4'b0100, 1'b1, 1'b1);
        check("t3_count", jcnt, 16'd6);

        // 5) enable low blocks the grant; enable high grants next cycle
        req = 4'b0000;
        step();
        en  = 1'b0;
        req = 4'b0010;
        repeat (5) step();
        check("t5_no_grant", 16'(router), 16'd0);
        check("t5_no_busy",  16'(busy),   16'd0);
        en = 1'b1;
        step();
        check("t5_grant", 16'(router), 16'h2);

        // 6) async reset in the middle of RUN
        step();
        check("t6_running", 16'(wrst_n), 16'd1);
        repeat (3) step();
        resetn = 1'b0;
        #1;
        check("t6_wresetn", 16'(wrst_n), 16'd0);
        check("t6_router",  16'(router), 16'd0);
        check("t6_busy",    16'(busy),   16'd0);
        check("t6_pulses",  16'({done, err}), 16'd0);
        check("t6_count",   jcnt, 16'd0);
        step();
        req    = 4'b0000;
        resetn = 1'b1;
        step();

        // 4) watchdog instance: silent writer errors out 100 cycles after RUN entry
        req_t = 4'b0001;
        k = 0;
        while (!wrst_n_t && k < 10) begin step(); k++; end
        check("t4_start", 16'(wrst_n_t), 16'd1);
        k = 0;
        while (err_t == 4'd0 && k < 200) begin step(); k++; end
        check("t4_latency", 16'(k), 16'd100);
        check("t4_error",   16'(err_t),    16'h1);
        check("t4_done",    16'(done_t),   16'd0);
        check("t4_wresetn", 16'(wrst_n_t), 16'd0);
        check("t4_count",   jcnt_t,        16'd1);
        req_t = 4'b0000;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
